// File: rtl/i2s_tdm_rx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tdm_rx
// Description : I2S / left-justified / TDM master receiver. Generates sck and
//               ws from the system clock, deserialises MSB-first slot data
//               and presents each word on a valid/ready stream with its
//               channel index and a sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tdm_rx #(
  parameter int  DATA_WIDTH = 16,
  parameter int  SLOT_WIDTH = 32,
  parameter int  NUM_CH     = 2,
  parameter int  CLK_DIV    = 4,
  localparam int CH_W       = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_en,
  input  logic                  i_mode,
  input  logic                  i_sd,
  output logic                  o_sck,
  output logic                  o_ws,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CH_W-1:0]       o_ch,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic                  o_ovf,
  input  logic                  i_ovf_clr
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(SLOT_WIDTH);

  localparam logic [DIV_W-1:0] C_DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] C_BIT_LAST  = BIT_W'(SLOT_WIDTH - 1);
  localparam logic [BIT_W-1:0] C_BIT_ONE   = BIT_W'(1);
  localparam logic [CH_W-1:0]  C_CH_LAST   = CH_W'(NUM_CH - 1);
  localparam bit               C_FULL_SLOT = (DATA_WIDTH == SLOT_WIDTH);
  // Bit counter value at which the final data bit of a word is sampled.
  localparam logic [BIT_W-1:0] C_LJ_LAST   = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] C_I2S_LAST  = C_FULL_SLOT ? '0 : BIT_W'(DATA_WIDTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_q;
  logic                    mode_q;
  logic [DIV_W-1:0]        div_q;
  logic [BIT_W-1:0]        bit_q;
  logic [CH_W-1:0]         slot_q;
  logic                    sck_q;
  logic                    ws_q;
  logic [DATA_WIDTH-1:0]   sr_q;
  logic                    busy_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [CH_W-1:0]         ch_q;
  logic                    vld_q;
  logic                    ovf_q;

  logic [BIT_W-1:0]        bit_d;
  logic [CH_W-1:0]         slot_d;
  logic                    mode_d;
  logic                    ws_d;

  logic                    w_div_wrap;
  logic                    w_rise;
  logic                    w_fall;
  logic                    w_frame_end;
  logic                    w_first;
  logic                    w_last;
  logic                    w_complete;
  logic [DATA_WIDTH-1:0]   w_shift;
  logic [CH_W-1:0]         w_prev_slot;
  logic [CH_W-1:0]         w_word_ch;

  // Word-select level for the bit position that starts after a fall.
  function automatic logic ws_for(input logic lj, input logic [BIT_W-1:0] b,
                                  input logic [CH_W-1:0] s);
    logic r;
    if (NUM_CH == 2) begin
      if (lj) r = (s == C_CH_LAST);
      else    r = (s == C_CH_LAST) ^ (b == C_BIT_LAST);
    end else begin
      if (lj) r = (s == '0) && (b == '0);
      else    r = (s == C_CH_LAST) && (b == C_BIT_LAST);
    end
    return r;
  endfunction

  assign w_div_wrap  = (state_q == ST_RUN) && (div_q == C_DIV_LAST);
  assign w_rise      = w_div_wrap && !sck_q;
  assign w_fall      = w_div_wrap && sck_q;
  assign w_frame_end = w_fall && (bit_q == C_BIT_LAST) && (slot_q == C_CH_LAST);

  // Next bit/slot position and the mode/ws that go with it.
  always_comb begin
    bit_d  = bit_q + 1'b1;
    slot_d = slot_q;
    if (bit_q == C_BIT_LAST) begin
      bit_d  = '0;
      slot_d = (slot_q == C_CH_LAST) ? '0 : slot_q + 1'b1;
    end
    mode_d = w_frame_end ? i_mode : mode_q;
    ws_d   = ws_for(mode_d, bit_d, slot_d);
  end

  // I2S words start one bit later; with full-width slots the LSB lands in
  // bit 0 of the following slot, so the word belongs to the previous slot.
  assign w_first     = mode_q ? (bit_q == '0) : (bit_q == C_BIT_ONE);
  assign w_last      = mode_q ? (bit_q == C_LJ_LAST) : (bit_q == C_I2S_LAST);
  assign w_complete  = w_rise && w_last && (busy_q || w_first);
  assign w_shift     = DATA_WIDTH'({sr_q, i_sd});
  assign w_prev_slot = (slot_q == '0) ? C_CH_LAST : slot_q - 1'b1;
  assign w_word_ch   = (!mode_q && C_FULL_SLOT) ? w_prev_slot : slot_q;

  // Control FSM: clock divider, sck/ws generation, bit and slot counters.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      slot_q  <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      div_q  <= '0;
      bit_q  <= '0;
      slot_q <= '0;
      sck_q  <= 1'b0;
      ws_q   <= 1'b0;
      if (i_en) begin
        state_q <= ST_RUN;
        mode_q  <= i_mode;
        ws_q    <= ws_for(i_mode, '0, '0);
      end
    end else begin
      if (w_div_wrap) begin
        div_q <= '0;
        if (w_fall) begin
          sck_q <= 1'b0;
          if (w_frame_end && !i_en) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            slot_q  <= '0;
            ws_q    <= 1'b0;
          end else begin
            bit_q  <= bit_d;
            slot_q <= slot_d;
            mode_q <= mode_d;
            ws_q   <= ws_d;
          end
        end else begin
          sck_q <= 1'b1;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  // Shift register; busy marks a word whose MSB has been captured.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      sr_q   <= '0;
      busy_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      busy_q <= 1'b0;
    end else if (w_rise) begin
      sr_q <= w_shift;
      if (w_complete)   busy_q <= 1'b0;
      else if (w_first) busy_q <= 1'b1;
    end
  end

  // Output stream register with drop-on-blocked and sticky overrun.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      data_q <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (w_complete && (!vld_q || i_rdy)) begin
        data_q <= w_shift;
        ch_q   <= w_word_ch;
        vld_q  <= 1'b1;
      end else if (vld_q && i_rdy) begin
        vld_q <= 1'b0;
      end
      if (w_complete && vld_q && !i_rdy) ovf_q <= 1'b1;
      else if (i_ovf_clr)                ovf_q <= 1'b0;
    end
  end

  assign o_sck  = sck_q;
  assign o_ws   = ws_q;
  assign o_data = data_q;
  assign o_ch   = ch_q;
  assign o_vld  = vld_q;
  assign o_ovf  = ovf_q;

endmodule
`default_nettype wire

// File: doc/i2s_tdm_rx.md
# i2s_tdm_rx

Parametrised I2S/TDM master receiver, successor to the fixed 16-bit stereo capture path. It generates the serial clock and word select from the system clock and deserialises MSB-first samples. It supports 2-channel I2S, left-justified, and N-slot TDM framing. Each completed sample is presented on a valid/ready stream tagged with its channel index, with sticky overrun reporting. It sits between the microphone pins and the downstream FIFO / ZCR / STE / mean-subtraction chain.

## Interface
- DATA_WIDTH, 16, sample bits captured per slot (MSB first); 1 ≤ DATA_WIDTH ≤ SLOT_WIDTH
- SLOT_WIDTH, 32, sck cycles per slot; ≥ 2
- NUM_CH, 2, slots per frame; 2 = stereo I2S/LJ, >2 = TDM; ≥ 2
- CLK_DIV, 4, sys clocks per sck half-period; ≥ 2
- i_sys_clk  in  1  system clock; only clock in the block
- i_sys_rst_n  in  1  asynchronous active-low reset
- i_en  in  1  capture enable, sampled only at frame boundaries
- i_mode  in  1  0 = I2S (1-bit delay), 1 = left-justified; sampled at frame boundaries
- i_sd  in  1  serial data from the codec/mic
- o_sck  out  1  serial clock
- o_ws  out  1  word select / frame sync
- o_data  out  DATA_WIDTH  captured sample
- o_ch  out  max(1,$clog2(NUM_CH))  slot index of o_data (0 = left/slot 0)
- o_vld  out  1  o_data/o_ch valid
- i_rdy  in  1  downstream accept
- o_ovf  out  1  sticky overrun flag
- i_ovf_clr  in  1  clears o_ovf

## Operation
- Reset values: o_sck=0, o_ws=0, o_data=0, o_ch=0, o_vld=0, o_ovf=0. Internal state is IDLE with div_cnt, bit_cnt and slot_cnt at 0.
- FSM IDLE: o_sck held 0, o_ws held 0. If i_en=1, latch i_mode into mode_q and go to RUN.
- FSM RUN: div_cnt counts 0..CLK_DIV-1 and wraps. o_sck toggles when div_cnt==CLK_DIV-1, so one sck period = 2·CLK_DIV sys clocks and the first rising edge comes CLK_DIV cycles after entering RUN.
- Rise event: the sys edge that drives o_sck 0→1. i_sd is sampled on that same edge.
- Fall event: the sys edge that drives o_sck 1→0. On a fall, bit_cnt advances 0..SLOT_WIDTH-1; on wrap, slot_cnt advances 0..NUM_CH-1.
- Frame boundary: the fall where both slot_cnt and bit_cnt wrap to 0. At that point i_en and i_mode are resampled. If i_en=0, go to IDLE with o_sck=0 and all counters 0.
- Data bit position: in LJ mode, slot bit b (0 = MSB) is sampled at the rise while bit_cnt==b. In I2S mode it is sampled while bit_cnt==b+1. For I2S with DATA_WIDTH==SLOT_WIDTH, the last bit is sampled at bit_cnt 0 of the next slot, or of the next frame after wrap.
- o_ws for NUM_CH==2: in LJ mode it is 0 during slot 0 and 1 during slot 1. In I2S mode, o_ws changes at the fall that starts bit_cnt==SLOT_WIDTH-1 of the preceding slot, i.e. one sck before the MSB.
- o_ws for NUM_CH>2: a one-sck-wide high pulse. In LJ mode it covers bit_cnt 0 of slot 0. In I2S mode it covers the last bit of slot NUM_CH-1, ending before the MSB of slot 0.
- Shift register: left-shifts i_sd in. On the rise that samples bit DATA_WIDTH-1, the word is complete.
- Completion, output empty or accepted: if o_vld=0, or o_vld=1 and i_rdy=1 in that cycle, load o_data and o_ch (the slot the word belongs to) and set o_vld=1 on that same edge.
- Completion, output blocked: if o_vld=1 and i_rdy=0, drop the new word, keep o_data/o_ch unchanged, and set o_ovf=1.
- Handshake: o_vld falls on the edge after o_vld&&i_rdy unless a new word loads on that same edge. o_data/o_ch are stable while o_vld=1 and i_rdy=0.
- i_ovf_clr=1: clears o_ovf. If an overrun occurs in the same cycle, set wins.
- Bits DATA_WIDTH..SLOT_WIDTH-1 of a slot are ignored.
- Reset mid-frame: asynchronous return to all reset values. A partial word is discarded and never emitted.
- i_en deasserted mid-frame: the current frame completes and all its words are emitted, then the block enters IDLE.

## Timing
- Latency: o_vld rises on the completing rise edge, so o_data is visible one sys cycle after that edge.
- Frame length: NUM_CH·SLOT_WIDTH·2·CLK_DIV sys clocks. There is no gap between frames while i_en=1.
- o_sck and o_ws are registered outputs, glitch-free, and change only on div_cnt wrap.
- Sustained throughput: one word per SLOT_WIDTH sck. i_rdy may be low for up to SLOT_WIDTH·2·CLK_DIV−1 cycles after o_vld without loss.

## Test plan
- Defaults, I2S mode, left=16'h8001 and right=16'h3333 driven on sck falls with a 1-bit delay → o_vld pulses with (o_ch=0, 16'h8001) then (o_ch=1, 16'h3333). o_ws period = 512 sys clocks; o_sck period = 8 sys clocks.
- i_mode=1, same words driven with no delay → same outputs. o_ws edges are aligned to the MSB fall.
- NUM_CH=4, SLOT_WIDTH=16, DATA_WIDTH=12, slots 12'hABC/12'h123/12'hFFF/12'h800 → four words with o_ch=0..3. o_ws is high for exactly 8 sys clocks once per 512-cycle frame.
- i_rdy=0 held across two completions → first word held, second dropped, o_ovf=1. i_ovf_clr pulse → o_ovf=0. The next word is delivered normally after i_rdy=1.
- i_sys_rst_n low mid-slot → all outputs 0 immediately. After release with i_en=1, the first emitted word is slot 0 of a fresh frame.
- i_en dropped at mid-frame → remaining slots still emitted, then o_sck stays 0 and no further o_vld. Re-asserting i_en restarts at slot 0.
